// File: rtl/alu_fifo_pkg.sv
// Shared types and width helpers for the ALU command pipeline.
// Optional feature macro: ALU_FIFO_DIV_EN (op 11 becomes divide instead of AND).
package alu_fifo_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_X   = 2'b11
  } op_e;

  // Command word: {op[1:0], a[OPW-1:0], b[OPW-1:0]}
  function automatic int cw(input int opw);
    return 2 + 2 * opw;
  endfunction

  // Result word: wide enough for the full product plus one flag/sign bit
  function automatic int rw(input int opw);
    return 2 * opw + 1;
  endfunction

endpackage

// File: rtl/alu_fifo_alu.sv
// Combinational executor for one command: op, a, b in; RW-bit result out.
// Macro ALU_FIFO_DIV_EN selects divide for op 11; otherwise op 11 is bitwise AND.
module alu_fifo_alu
  import alu_fifo_pkg::*;
#(
  parameter  int OPW = 4,
  localparam int RW  = rw(OPW)
) (
  input  logic [1:0]     op,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [RW-1:0]  result
);

  logic [RW-1:0]    a_ext;
  logic [RW-1:0]    b_ext;
  logic [2*OPW-1:0] prod;
  logic [RW-1:0]    op_x_res;

  assign a_ext = {{(RW-OPW){1'b0}}, a};
  assign b_ext = {{(RW-OPW){1'b0}}, b};
  assign prod  = {{OPW{1'b0}}, a} * {{OPW{1'b0}}, b};

`ifdef ALU_FIFO_DIV_EN
  logic [OPW-1:0] b_safe;
  logic [OPW-1:0] quo;
  logic [OPW-1:0] rem;
  logic           div_zero;

  // Divisor forced to 1 when b is zero so the divider never sees 0; that case
  // is overridden by the flagged result below anyway.
  assign div_zero = (b == '0);
  assign b_safe   = div_zero ? {{(OPW-1){1'b0}}, 1'b1} : b;
  assign quo      = div_zero ? {OPW{1'b1}} : (a / b_safe);
  assign rem      = div_zero ? a : (a % b_safe);
  assign op_x_res = {div_zero, rem, quo};
`else
  assign op_x_res = {{(RW-OPW){1'b0}}, a & b};
`endif

  // Opcode decode; subtract in RW bits equals the sign-extended OPW+1 difference
  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_ADD:  result = a_ext + b_ext;
      OP_SUB:  result = a_ext - b_ext;
      OP_MUL:  result = {1'b0, prod};
      OP_X:    result = op_x_res;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_fifo_pipe.sv
// ALU command processor: DEPTH-entry command FIFO feeding a one-deep,
// backpressured result register. Commands complete strictly in order.
// Macro ALU_FIFO_DIV_EN (passed through to alu_fifo_alu) enables divide on op 11.
module alu_fifo_pipe
  import alu_fifo_pkg::*;
#(
  parameter  int OPW   = 4,
  parameter  int DEPTH = 8,
  localparam int CW    = cw(OPW),
  localparam int RW    = rw(OPW),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] data,
  input  logic          valid,
  output logic          ready,
  output logic [RW-1:0] result,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [LW-1:0] level
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [CW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [RW-1:0] result_reg;
  logic          res_valid_reg;

  logic          push;
  logic          pop;
  logic [CW-1:0] head;
  logic [RW-1:0] alu_out;

  // ready comes from the registered count only: a same-cycle pop does not
  // open a slot for the incoming command.
  assign ready = (level_reg < DEPTH_L);
  assign push  = valid && ready;
  assign pop   = (level_reg != '0) && (!res_valid_reg || res_ready);

  // Head is read asynchronously so a command can execute on the edge right
  // after it was written (one-cycle latency through an empty FIFO).
  assign head = mem[rd_ptr_reg];

  alu_fifo_alu #(
    .OPW (OPW)
  ) u_alu (
    .op     (head[CW-1:CW-2]),
    .a      (head[2*OPW-1:OPW]),
    .b      (head[OPW-1:0]),
    .result (alu_out)
  );

  // Command storage write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        level_reg <= level_reg + LW'(1);
      end else if (pop && !push) begin
        level_reg <= level_reg - LW'(1);
      end
    end
  end

  // Result stage: load on pop, drop when consumed with nothing new, else hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_reg    <= '0;
      res_valid_reg <= 1'b0;
    end else if (pop) begin
      result_reg    <= alu_out;
      res_valid_reg <= 1'b1;
    end else if (res_valid_reg && res_ready) begin
      res_valid_reg <= 1'b0;
    end
  end

  assign result    = result_reg;
  assign res_valid = res_valid_reg;
  assign level     = level_reg;

endmodule

// File: tb/tb_alu_fifo_pipe.sv
// Scoreboard bench for alu_fifo_pipe (default OPW=4, DEPTH=8).
// Define ALU_FIFO_DIV_EN for both bench and RTL to exercise the divide option.
`timescale 1ns/1ps
module tb_alu_fifo_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] data;
  logic       valid;
  logic       ready;
  logic [8:0] result;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] level;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [8:0] exp_q  [$];
  int         cons_q [$];

  alu_fifo_pipe #(.OPW(4), .DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .result    (result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .level     (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a result is consumed on the next rising edge when both flags are high
  always @(negedge clk) begin
    if (reset && res_valid && res_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: got %03h with empty scoreboard", result);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if (result !== e) begin
          n_bad++;
          $display("FAIL result: got %03h expected %03h", result, e);
        end else begin
          $display("result ok %03h at cycle %0d", result, cyc);
        end
      end
      cons_q.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a command and hold it until the edge that accepts it
  task automatic send(input logic [9:0] cmd, input logic [8:0] exp);
    bit done;
    done = 0;
    @(posedge clk);
    #1;
    data  = cmd;
    valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (ready) begin
        exp_q.push_back(exp);
        $display("push %03h expect %03h", cmd, exp);
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: cmd %03h never accepted, ready=%0b", cmd, ready);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk({name, "_drained_left"}, exp_q.size(), 0);
    @(negedge clk);
  endtask

  logic [9:0] bp_cmd [9] = '{10'h151, 10'h232, 10'h0FF, 10'h115, 10'h2FF,
                             10'h0A5, 10'h1F3, 10'h254, 10'h000};
  logic [8:0] bp_exp [9] = '{9'h004, 9'h006, 9'h01E, 9'h1FC, 9'h0E1,
                             9'h00F, 9'h00C, 9'h014, 9'h000};

  initial begin
    reset     = 1'b0;
    data      = '0;
    valid     = 1'b0;
    res_ready = 1'b1;
    #20;
    reset = 1'b1;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_level", level, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_result", result, 9'h000);

    // Latency: push at edge N, result valid after edge N+1
    @(posedge clk);
    #1;
    data  = 10'h151;
    valid = 1'b1;
    exp_q.push_back(9'h004);
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk("lat_level_after_push", level, 1);
    chk("lat_res_valid_after_push", res_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_res_valid_next", res_valid, 1);
    chk("lat_result_next", result, 9'h004);
    chk("lat_level_next", level, 0);
    drain("lat");

    // Back-to-back with sustained throughput
    cons_q.delete();
    send(10'h151, 9'h004);
    send(10'h232, 9'h006);
    send(10'h0FF, 9'h01E);
    idle();
    drain("b2b");
    chk("b2b_count", cons_q.size(), 3);
    if (cons_q.size() == 3) begin
      chk("b2b_gap01", cons_q[1] - cons_q[0], 1);
      chk("b2b_gap12", cons_q[2] - cons_q[1], 1);
    end

    // Negative subtract and maximum product
    send(10'h115, 9'h1FC);
    send(10'h2FF, 9'h0E1);
    idle();
    drain("negmul");

    // Op 11
`ifdef ALU_FIFO_DIV_EN
    send(10'h372, 9'h013);
    send(10'h370, 9'h17F);
`else
    send(10'h372, 9'h002);
`endif
    idle();
    drain("opx");

    // Backpressure: capacity is DEPTH+1 commands
    res_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(bp_cmd[i], bp_exp[i]);
    @(posedge clk);
    #1;
    data = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready_low", ready, 0);
      chk("bp_level_full", level, 8);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_result_stable", result, 9'h004);
    end
    valid = 1'b0;
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    drain("bp");
    chk("bp_level_empty", level, 0);

    // Asynchronous reset with work in flight
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(bp_cmd[i], bp_exp[i]);
    idle();
    chk("mid_level_before", level, 5);
    chk("mid_res_valid_before", res_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_level_reset", level, 0);
    chk("mid_res_valid_reset", res_valid, 0);
    chk("mid_ready_reset", ready, 1);
    exp_q.delete();
    @(negedge clk);
    reset     = 1'b1;
    res_ready = 1'b1;
    send(10'h151, 9'h004);
    idle();
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
